// File: rtl/weight_loader.sv
// Serial-to-column weight loader: packs ROWS serial words into one column, then strobes it into weight RAM.
// Optional WEIGHT_LOADER_CHECKSUM_EN adds an XOR checksum output over the words of the current load.

module weight_loader_slice #(
  parameter int BITWIDTH = 18
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                wr,
  input  logic [BITWIDTH-1:0] d,
  output logic [BITWIDTH-1:0] q
);
  always_ff @(posedge clock) begin
    if (reset)   q <= '0;
    else if (wr) q <= d;
  end
endmodule

module weight_loader #(
  parameter  int ROWS           = 16,
  parameter  int COLS           = 2,
  parameter  int QN             = 6,
  parameter  int QM             = 11,
  localparam int BITWIDTH       = QN + QM + 1,
  localparam int ADDR_BITWIDTH  = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int LAYER_BITWIDTH = BITWIDTH * ROWS
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      beginLoad,
  input  logic [BITWIDTH-1:0]       dataIn,
  input  logic                      dataValid,
  output logic                      dataReady,
  output logic [ADDR_BITWIDTH-1:0]  colAddressWrite,
  output logic                      writeEn,
  output logic [LAYER_BITWIDTH-1:0] weightMemInput,
  output logic                      busy,
  output logic                      loadDone
`ifdef WEIGHT_LOADER_CHECKSUM_EN
  ,
  output logic [BITWIDTH-1:0]       checksum
`endif
);
  localparam int ROW_BITS = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]               state;
  logic [ROW_BITS-1:0]      row;
  logic [ADDR_BITWIDTH-1:0] col;
  logic                     accept;
  logic                     last_row;
  logic                     last_col;
  logic [ROWS-1:0]          slice_wr;

  // dataReady is a register that tracks FILL exactly, so it can gate acceptance directly.
  assign accept   = (state == S_FILL) && dataValid && dataReady;
  assign last_row = (row == ROW_BITS'(ROWS - 1));
  assign last_col = (col == ADDR_BITWIDTH'(COLS - 1));

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    assign slice_wr[r] = accept && (row == ROW_BITS'(r));
    weight_loader_slice #(.BITWIDTH(BITWIDTH)) u_slice (
      .clock (clock),
      .reset (reset),
      .wr    (slice_wr[r]),
      .d     (dataIn),
      .q     (weightMemInput[r*BITWIDTH +: BITWIDTH])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= S_IDLE;
      row             <= '0;
      col             <= '0;
      dataReady       <= 1'b0;
      writeEn         <= 1'b0;
      loadDone        <= 1'b0;
      busy            <= 1'b0;
      colAddressWrite <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (beginLoad) begin
            state     <= S_FILL;
            row       <= '0;
            col       <= '0;
            dataReady <= 1'b1;
            busy      <= 1'b1;
          end
        end
        S_FILL: begin
          if (accept) begin
            if (last_row) begin
              state           <= S_WRITE;
              row             <= '0;
              dataReady       <= 1'b0;
              writeEn         <= 1'b1;
              colAddressWrite <= col;
            end else begin
              row <= row + 1'b1;
            end
          end
        end
        S_WRITE: begin
          writeEn <= 1'b0;
          if (last_col) begin
            state    <= S_DONE;
            loadDone <= 1'b1;
          end else begin
            state     <= S_FILL;
            col       <= col + 1'b1;
            dataReady <= 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          loadDone <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

`ifdef WEIGHT_LOADER_CHECKSUM_EN
  // Cleared only by a start that is actually taken; a beginLoad mid-load must not wipe it.
  always_ff @(posedge clock) begin
    if (reset)                             checksum <= '0;
    else if (state == S_IDLE && beginLoad) checksum <= '0;
    else if (accept)                       checksum <= checksum ^ dataIn;
  end
`endif

endmodule

// File: tb/tb_weight_loader.sv
// Randomized bench for weight_loader: a word-stream model predicts RAM writes, latency and checksum.
`timescale 1ns/1ps
module tb_weight_loader;
  localparam int ROWS = 16;
  localparam int COLS = 2;
  localparam int BW   = 18;
  localparam int NW   = ROWS * COLS;

  logic clock = 1'b0;
  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  logic               reset, begin_load, data_valid;
  logic [BW-1:0]      data_in;
  logic               data_ready, write_en, busy, load_done;
  logic [0:0]         col_addr;
  logic [ROWS*BW-1:0] mem;

  logic               s_begin, s_valid;
  logic [BW-1:0]      s_in;
  logic               s_ready, s_we, s_busy, s_done;
  logic [0:0]         s_addr;
  logic [4*BW-1:0]    s_mem;

`ifdef WEIGHT_LOADER_CHECKSUM_EN
  logic [BW-1:0]      checksum, s_chk, c_chk;
  logic               c_begin, c_valid, c_ready, c_we, c_busy, c_done;
  logic [BW-1:0]      c_in;
  logic [0:0]         c_addr;
  logic [3*BW-1:0]    c_mem;
`endif

  weight_loader #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clock(clock), .reset(reset), .beginLoad(begin_load), .dataIn(data_in),
    .dataValid(data_valid), .dataReady(data_ready), .colAddressWrite(col_addr),
    .writeEn(write_en), .weightMemInput(mem), .busy(busy), .loadDone(load_done)
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  weight_loader #(.ROWS(4), .COLS(1)) dut_small (
    .clock(clock), .reset(reset), .beginLoad(s_begin), .dataIn(s_in),
    .dataValid(s_valid), .dataReady(s_ready), .colAddressWrite(s_addr),
    .writeEn(s_we), .weightMemInput(s_mem), .busy(s_busy), .loadDone(s_done)
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    , .checksum(s_chk)
`endif
  );

`ifdef WEIGHT_LOADER_CHECKSUM_EN
  weight_loader #(.ROWS(3), .COLS(1)) dut_chk (
    .clock(clock), .reset(reset), .beginLoad(c_begin), .dataIn(c_in),
    .dataValid(c_valid), .dataReady(c_ready), .colAddressWrite(c_addr),
    .writeEn(c_we), .weightMemInput(c_mem), .busy(c_busy), .loadDone(c_done),
    .checksum(c_chk)
  );
`endif

  task automatic test_reset;
    reset = 1'b1;
    begin_load = 1'b1;
    s_begin = 1'b1;
    repeat (3) @(negedge clock);
    tests++;
    if ({data_ready, write_en, load_done, busy} !== 4'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b want 0000", {data_ready, write_en, load_done, busy});
    end
    tests++;
    if (col_addr !== 1'b0 || mem !== '0) begin
      fails++;
      $display("FAIL reset_data: got addr %h mem %h want 0", col_addr, mem);
    end
    tests++;
    if ({s_ready, s_we, s_done, s_busy} !== 4'b0 || s_mem !== '0) begin
      fails++;
      $display("FAIL reset_small: got %b mem %h want 0", {s_ready, s_we, s_done, s_busy}, s_mem);
    end
    reset = 1'b0;
    begin_load = 1'b0;
    s_begin = 1'b0;
    @(negedge clock);
    tests++;
    if (busy !== 1'b0 || s_busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_priority: got busy %b/%b want 0/0", busy, s_busy);
    end
  endtask

  // gap_mode: 0 none, 1 one idle cycle before every word but the first, 2 random 0..3
  task automatic test_load(input string name, input int gap_mode, input bit spur,
                           input int abort_at, input bit ascending);
    logic [BW-1:0]      w [NW];
    int                 g [NW];
    logic [ROWS*BW-1:0] exp_col [$];
    int                 exp_addr [$];
    logic [ROWS*BW-1:0] col, last_col, ecol;
    logic [BW-1:0]      xsum;
    int gap_total, idx, gaps_left, kb, writes, lat, eaddr, exp_lat;
    bit done, aborted, last_gap;
    gap_total = 0; xsum = '0; idx = 0; writes = 0; done = 0; aborted = 0; last_gap = 0;
    col = '0;
    for (int i = 0; i < NW; i++) begin
      w[i] = ascending ? BW'(i) : BW'($urandom);
      g[i] = (gap_mode == 0) ? 0 : (gap_mode == 1) ? ((i == 0) ? 0 : 1) : int'($urandom_range(0, 3));
      gap_total += g[i];
      xsum ^= w[i];
    end
    for (int c = 0; c < COLS; c++) begin
      for (int r = 0; r < ROWS; r++) col[r*BW +: BW] = w[c*ROWS + r];
      exp_col.push_back(col);
      exp_addr.push_back(c);
    end
    last_col = col;
    exp_lat = ROWS * COLS + COLS + 2 + gap_total;
    gaps_left = g[0];

    @(negedge clock);
    begin_load = 1'b1;
    data_valid = 1'b0;
    kb = cyc;
    for (int t = 0; t < 600 && !done && !aborted; t++) begin
      @(negedge clock);
      begin_load = 1'b0;
      tests++;
      if (busy !== 1'b1) begin
        fails++;
        $display("FAIL %s busy: got %b want 1 at word %0d", name, busy, idx);
      end
      if (last_gap) begin
        tests++;
        if (data_ready !== 1'b1) begin
          fails++;
          $display("FAIL %s gap_ready: got %b want 1", name, data_ready);
        end
      end
      last_gap = 0;
      if (write_en === 1'b1) begin
        writes++;
        tests++;
        if (exp_col.size() == 0) begin
          fails++;
          $display("FAIL %s extra_write: got write #%0d want none", name, writes);
        end else begin
          ecol = exp_col.pop_front();
          eaddr = exp_addr.pop_front();
          if (col_addr !== 1'(eaddr) || mem !== ecol || data_ready !== 1'b0) begin
            fails++;
            $display("FAIL %s write: got addr %h rdy %b data %h want addr %0d rdy 0 data %h",
                     name, col_addr, data_ready, mem, eaddr, ecol);
          end
        end
      end
      if (load_done === 1'b1) begin
        done = 1;
        lat = cyc - kb + 1;
        tests++;
        if (lat != exp_lat || data_ready !== 1'b0) begin
          fails++;
          $display("FAIL %s latency: got %0d rdy %b want %0d rdy 0", name, lat, data_ready, exp_lat);
        end
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        tests++;
        if (checksum !== xsum) begin
          fails++;
          $display("FAIL %s checksum: got %h want %h", name, checksum, xsum);
        end
`endif
      end
      if (abort_at > 0 && idx == abort_at) begin
        reset = 1'b1;
        data_valid = 1'b0;
        aborted = 1;
      end else if (!done) begin
        data_valid = 1'($urandom_range(0, 1));
        data_in = BW'($urandom);
        if (data_ready === 1'b1 && idx < NW) begin
          if (gaps_left > 0) begin
            data_valid = 1'b0;
            gaps_left--;
            last_gap = 1;
          end else begin
            data_valid = 1'b1;
            data_in = w[idx];
            idx++;
            gaps_left = (idx < NW) ? g[idx] : 0;
          end
        end
        if (spur && idx == 5 && data_ready === 1'b1) begin_load = 1'b1;
      end else begin
        data_valid = 1'b0;
      end
    end
    data_valid = 1'b0;

    if (aborted) begin
      @(negedge clock);
      tests++;
      if ({data_ready, write_en, load_done, busy} !== 4'b0 || col_addr !== 1'b0 || mem !== '0) begin
        fails++;
        $display("FAIL %s abort_zero: got %b addr %h mem %h want all 0", name,
                 {data_ready, write_en, load_done, busy}, col_addr, mem);
      end
      reset = 1'b0;
      tests++;
      if (writes != 1) begin
        fails++;
        $display("FAIL %s abort_writes: got %0d want 1", name, writes);
      end
    end else begin
      if (!done) begin
        tests++;
        fails++;
        $display("FAIL %s timeout: got no loadDone want one within 600 cycles", name);
      end
      tests++;
      if (writes != COLS) begin
        fails++;
        $display("FAIL %s write_count: got %0d want %0d", name, writes, COLS);
      end
      @(negedge clock);
      tests++;
      if (load_done !== 1'b0 || busy !== 1'b0 || col_addr !== 1'(COLS - 1) || mem !== last_col) begin
        fails++;
        $display("FAIL %s idle_hold: got done %b busy %b addr %h mem %h want 0 0 %0d %h",
                 name, load_done, busy, col_addr, mem, COLS - 1, last_col);
      end
    end
  endtask

  task automatic test_single_col;
    logic [4*BW-1:0] exp;
    int kb, idx, writes, lat;
    bit done;
    idx = 0; writes = 0; done = 0;
    for (int r = 0; r < 4; r++) exp[r*BW +: BW] = BW'(r + 1);
    @(negedge clock);
    s_begin = 1'b1;
    s_valid = 1'b0;
    kb = cyc;
    for (int t = 0; t < 40 && !done; t++) begin
      @(negedge clock);
      s_begin = 1'b0;
      if (s_we === 1'b1) begin
        writes++;
        tests++;
        if (s_addr !== 1'b0 || s_mem !== exp) begin
          fails++;
          $display("FAIL single_col_write: got addr %h data %h want 0 %h", s_addr, s_mem, exp);
        end
      end
      if (s_done === 1'b1) begin
        done = 1;
        lat = cyc - kb + 1;
        tests++;
        if (lat != 7) begin
          fails++;
          $display("FAIL single_col_latency: got %0d want 7", lat);
        end
      end
      s_valid = (s_ready === 1'b1) && (idx < 4);
      s_in = BW'(idx + 1);
      if (s_valid) idx++;
    end
    s_valid = 1'b0;
    tests++;
    if (!done || writes != 1) begin
      fails++;
      $display("FAIL single_col_count: got done %0d writes %0d want 1 1", done, writes);
    end
  endtask

`ifdef WEIGHT_LOADER_CHECKSUM_EN
  task automatic test_checksum_small;
    logic [BW-1:0] w [3];
    int idx;
    bit done;
    w[0] = 18'd1; w[1] = 18'd2; w[2] = 18'd4;
    idx = 0; done = 0;
    @(negedge clock);
    c_begin = 1'b1;
    c_valid = 1'b0;
    for (int t = 0; t < 40 && !done; t++) begin
      @(negedge clock);
      c_begin = 1'b0;
      if (c_done === 1'b1) begin
        done = 1;
        tests++;
        if (c_chk !== 18'd7) begin
          fails++;
          $display("FAIL checksum_small: got %h want 7", c_chk);
        end
      end
      c_valid = (c_ready === 1'b1) && (idx < 3);
      c_in = (idx < 3) ? w[idx] : '0;
      if (c_valid) idx++;
    end
    c_valid = 1'b0;
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL checksum_small_timeout: got no loadDone want one");
    end
  endtask
`endif

  initial begin
    reset = 1'b1; begin_load = 1'b0; data_valid = 1'b0; data_in = '0;
    s_begin = 1'b0; s_valid = 1'b0; s_in = '0;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    c_begin = 1'b0; c_valid = 1'b0; c_in = '0;
`endif
    test_reset();
    test_load("basic", 0, 1'b0, 0, 1'b1);
    test_load("gaps", 1, 1'b0, 0, 1'b1);
    for (int i = 0; i < 3; i++) test_load("random", 2, 1'b0, 0, 1'b0);
    test_load("abort", 0, 1'b0, 20, 1'b1);
    test_load("after_abort", 0, 1'b0, 0, 1'b1);
    test_load("begin_in_fill", 2, 1'b1, 0, 1'b0);
    test_load("back_to_back", 0, 1'b0, 0, 1'b0);
    test_single_col();
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    test_checksum_small();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish before 500us");
    $fatal(1, "watchdog expired");
  end
endmodule
